// File: rtl/sram_responder.sv
// Word-organised SRAM responder for the core's fetch and data ports.
// Round-robin arbitration, request/ack handshake, configurable wait states.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last_grant;
    logic             cur_data, cur_we;
    logic [3:0]       cur_sel;
    logic [31:0]      cur_addr, cur_wdata;

    logic [31:0] memory [0:DEPTH-1];

    logic                  take_c, gnt_data_c, do_access_c, fault_c;
    logic                  acc_data_c, acc_we_c;
    logic [3:0]            acc_sel_c;
    logic [31:0]           acc_addr_c, acc_wdata_c;
    logic [ADDR_WIDTH-1:0] idx_c;

    // Next state plus the access view: live inputs in IDLE, latched request afterwards
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        take_c     = 1'b0;
        gnt_data_c = mem_req && (!if_req || !last_grant);
        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    take_c  = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state == IDLE) begin
            acc_data_c  = gnt_data_c;
            acc_we_c    = gnt_data_c && mem_we;
            acc_sel_c   = mem_sel;
            acc_addr_c  = gnt_data_c ? mem_addr : if_addr;
            acc_wdata_c = mem_wdata;
        end else begin
            acc_data_c  = cur_data;
            acc_we_c    = cur_we;
            acc_sel_c   = cur_sel;
            acc_addr_c  = cur_addr;
            acc_wdata_c = cur_wdata;
        end

        do_access_c = (state_d == RESP) && (state != RESP);
        fault_c     = (acc_addr_c[1:0] != 2'b00) || ((acc_addr_c >> (ADDR_WIDTH + 2)) != 32'd0);
        idx_c       = acc_addr_c[ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            cur_data   <= 1'b0;
            cur_we     <= 1'b0;
            cur_sel    <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (take_c) begin
                cur_data  <= acc_data_c;
                cur_we    <= acc_we_c;
                cur_sel   <= acc_sel_c;
                cur_addr  <= acc_addr_c;
                cur_wdata <= acc_wdata_c;
            end
            if_ack  <= do_access_c && !acc_data_c;
            mem_ack <= do_access_c && acc_data_c;
            err     <= do_access_c && fault_c;
            if (do_access_c) begin
                last_grant <= acc_data_c;
                if (!acc_we_c) begin
                    if (acc_data_c) mem_rdata <= fault_c ? 32'd0 : memory[idx_c];
                    else            if_rdata  <= fault_c ? 32'd0 : memory[idx_c];
                end
            end
        end
    end

    // Array is never reset; byte-masked write on the edge entering RESP
    always_ff @(posedge clk) begin
        if (do_access_c && acc_we_c && !fault_c) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel_c[b]) memory[idx_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic        if_ack, mem_ack, err;
    logic [31:0] if_rdata, mem_rdata;

    logic        if0_req;
    logic [31:0] if0_addr;
    logic        if0_ack, mem0_ack, err0;
    logic [31:0] if0_rdata, mem0_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if0_req), .if_addr(if0_addr), .if_ack(if0_ack), .if_rdata(if0_rdata),
        .mem_req(1'b0), .mem_we(1'b0), .mem_sel(4'h0), .mem_addr(32'h0),
        .mem_wdata(32'h0), .mem_ack(mem0_ack), .mem_rdata(mem0_rdata), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop the scoreboard on every ack of the main instance
    always @(negedge clk) begin
        if (!rst && (if_ack || mem_ack)) begin
            exp_t e;
            if (if_ack && mem_ack) check("dual_ack", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(mem_ack), 32'(e.port));
                if (e.chk_data) check("rdata", e.port ? mem_rdata : if_rdata, e.data);
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic push(input logic port, input logic [31:0] data, input logic chk, input logic e_err);
        exp_t e;
        e.port = port; e.data = data; e.chk_data = chk; e.err = e_err;
        sb.push_back(e);
    endtask

    task automatic txn(input logic port, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input logic experr);
        int  n;
        logic got;
        @(negedge clk);
        push(port, exp, !we, experr);
        if (port) begin
            mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = port ? mem_ack : if_ack;
        end
        check("ack_latency", 32'(n), 32'd3);
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(port ? mem_ack : if_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acks;
        int ack_cyc [4];
        int cyc;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        if0_req = 1'b0; if0_addr = '0;

        dut.memory[0]  = 32'h3402_0020;
        dut.memory[1]  = 32'h0BAD_F00D;
        dut.memory[2]  = 32'h2222_2222;
        dut.memory[4]  = 32'h1111_1111;
        dut0.memory[0] = 32'hA0A0_0001;
        dut0.memory[1] = 32'hB0B0_0002;

        repeat (2) @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);

        // Both ports requesting from reset: data, fetch, data, fetch
        push(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
        push(1'b0, 32'h3402_0020, 1'b1, 1'b0);
        push(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
        push(1'b0, 32'h3402_0020, 1'b1, 1'b0);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h4;
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_ack || mem_ack) begin
                ack_cyc[acks] = cyc;
                acks++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        check("tie_ack_count", 32'(acks), 32'd4);
        check("tie_first_cyc", 32'(ack_cyc[0]), 32'd3);
        for (int i = 1; i < 4; i++) check("tie_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        repeat (2) @(negedge clk);

        // Basic fetch, byte-masked write, read-back
        txn(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h3402_0020, 1'b0);
        txn(1'b1, 1'b1, 4'b0101, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h11AD_11EF, 1'b0);
        txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h11AD_11EF, 1'b0);

        // Faulting accesses: misaligned and out of range
        txn(1'b1, 1'b0, 4'hF, 32'h2, 32'h0, 32'h0, 1'b1);
        txn(1'b1, 1'b1, 4'hF, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        txn(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1);
        txn(1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        txn(1'b0, 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1);
        check("fault_mem0", dut.memory[0], 32'h3402_0020);
        txn(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h3402_0020, 1'b0);

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h8; mem_wdata = 32'hAAAA_AAAA;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_abort_ack", 32'(mem_ack || if_ack), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_ack_after", 32'(mem_ack || if_ack), 32'd0);
        check("rst_abort_mem2", dut.memory[2], 32'h2222_2222);
        txn(1'b0, 1'b0, 4'h0, 32'h8, 32'h0, 32'h2222_2222, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Zero wait states: back-to-back fetches ack in cycles 1 and 3
        @(negedge clk);
        if0_req = 1'b1; if0_addr = 32'h0;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0_ack && n < 10);
        check("w0_first_lat", 32'(n), 32'd1);
        check("w0_first_data", if0_rdata, 32'hA0A0_0001);
        check("w0_first_err", 32'(err0), 32'd0);
        if0_addr = 32'h4;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0_ack && n < 10);
        if0_req = 1'b0;
        check("w0_second_gap", 32'(n), 32'd2);
        check("w0_second_data", if0_rdata, 32'hB0B0_0002);
        check("w0_no_mem_ack", 32'(mem0_ack), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
